// File: rtl/compress_scheduler.sv
// Compression job sequencer: streams one sketch row from memory into the selected
// engines through a 2-entry skid buffer, then waits for engine completion or timeout.
module compress_scheduler #(
  parameter int unsigned NUM_COUNTER = 10,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic              SYS_CLK,
  input  logic              RESET,
  input  logic              Start,
  input  logic [1:0]        Mode,
  output logic              Busy,
  output logic              Mem_Rd_En,
  output logic [ADDR_W-1:0] Mem_Rd_Addr,
  input  logic [31:0]       Mem_Rd_Data,
  output logic [31:0]       Counter,
  output logic              Counter_Valid,
  input  logic              Counter_Ready,
  output logic              Last,
  output logic              Te_En,
  output logic              Ss_En,
  input  logic              Te_Done,
  input  logic              Ss_Done,
  input  logic              Flag_TowerEncoding,
  input  logic              Flag_SketchSensing,
  output logic              Done,
  output logic [1:0]        Result,
  output logic              Error
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StStream = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StReport = 2'd3;

  localparam int unsigned IdxW = ADDR_W + 1;
  localparam int unsigned TmW  = $clog2(TIMEOUT + 1);

  localparam logic [IdxW-1:0] NumCnt  = IdxW'(NUM_COUNTER);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_COUNTER - 1);
  localparam logic [TmW-1:0]  TmLast  = TmW'(TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic [IdxW-1:0] rd_idx_q, rd_idx_d;
  logic [IdxW-1:0] out_idx_q, out_idx_d;
  logic            rd_pend_q;
  logic [31:0]     buf0_q, buf0_d;
  logic [31:0]     buf1_q, buf1_d;
  logic [1:0]      buf_cnt_q, buf_cnt_d;
  logic [TmW-1:0]  tmr_q, tmr_d;
  logic            te_en_q, te_en_d;
  logic            ss_en_q, ss_en_d;
  logic            te_seen_q, te_seen_d;
  logic            ss_seen_q, ss_seen_d;
  logic            te_flag_q, te_flag_d;
  logic            ss_flag_q, ss_flag_d;
  logic [1:0]      result_q, result_d;
  logic            error_q, error_d;

  logic            in_stream;
  logic            accept;
  logic [2:0]      occ;
  logic            track_done;
  logic            te_hit;
  logic            ss_hit;
  logic            all_done;

  assign in_stream     = (state_q == StStream);
  assign Counter_Valid = in_stream && (buf_cnt_q != 2'd0);
  assign accept        = Counter_Valid && Counter_Ready;

  // Occupancy after this cycle's accept; a new read may only bring it to 2.
  assign occ       = {1'b0, buf_cnt_q} + {2'b00, rd_pend_q} - {2'b00, accept};
  assign Mem_Rd_En = in_stream && (rd_idx_q < NumCnt) && (occ <= 3'd1);

  assign Mem_Rd_Addr = rd_idx_q[ADDR_W-1:0];
  assign Counter     = Counter_Valid ? buf0_q : 32'd0;
  assign Last        = Counter_Valid && (out_idx_q == LastIdx);

  assign Busy   = (state_q != StIdle);
  assign Done   = (state_q == StReport);
  assign Te_En  = te_en_q;
  assign Ss_En  = ss_en_q;
  assign Result = result_q;
  assign Error  = error_q;

  assign track_done = (state_q == StStream) || (state_q == StWait);
  assign te_hit     = track_done && te_en_q && Te_Done && !te_seen_q;
  assign ss_hit     = track_done && ss_en_q && Ss_Done && !ss_seen_q;
  assign all_done   = (!te_en_q || te_seen_q || te_hit) && (!ss_en_q || ss_seen_q || ss_hit);

  // Skid buffer: pop shifts entry 1 forward, returning read data lands behind the head.
  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_cnt_d = buf_cnt_q;
    if (accept) begin
      buf0_d    = buf1_q;
      buf_cnt_d = buf_cnt_q - 2'd1;
    end
    if (rd_pend_q) begin
      if (buf_cnt_d == 2'd0) begin
        buf0_d = Mem_Rd_Data;
      end else begin
        buf1_d = Mem_Rd_Data;
      end
      buf_cnt_d = buf_cnt_d + 2'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    out_idx_d = out_idx_q;
    tmr_d     = tmr_q;
    te_en_d   = te_en_q;
    ss_en_d   = ss_en_q;
    te_seen_d = te_seen_q;
    ss_seen_d = ss_seen_q;
    te_flag_d = te_flag_q;
    ss_flag_d = ss_flag_q;
    result_d  = result_q;
    error_d   = error_q;

    if (te_hit) begin
      te_seen_d = 1'b1;
      te_flag_d = Flag_TowerEncoding;
    end
    if (ss_hit) begin
      ss_seen_d = 1'b1;
      ss_flag_d = Flag_SketchSensing;
    end

    case (state_q)
      StIdle: begin
        if (Start) begin
          rd_idx_d  = '0;
          out_idx_d = '0;
          tmr_d     = '0;
          te_seen_d = 1'b0;
          ss_seen_d = 1'b0;
          te_flag_d = 1'b0;
          ss_flag_d = 1'b0;
          result_d  = 2'b00;
          if (Mode != 2'b00) begin
            state_d = StStream;
            te_en_d = Mode[0];
            ss_en_d = Mode[1];
            error_d = 1'b0;
          end else begin
            state_d = StReport;
            te_en_d = 1'b0;
            ss_en_d = 1'b0;
            error_d = 1'b1;
          end
        end
      end
      StStream: begin
        if (Mem_Rd_En) begin
          rd_idx_d = rd_idx_q + 1'b1;
        end
        if (accept) begin
          out_idx_d = out_idx_q + 1'b1;
          if (Last) begin
            state_d = StWait;
            tmr_d   = '0;
          end
        end
      end
      StWait: begin
        // Completion is checked first so it wins a tie with the timeout.
        if (all_done) begin
          state_d  = StReport;
          error_d  = 1'b0;
          result_d = {ss_flag_d, te_flag_d};
        end else if (tmr_q == TmLast) begin
          state_d  = StReport;
          error_d  = 1'b1;
          result_d = {ss_flag_d, te_flag_d};
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        te_en_d = 1'b0;
        ss_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      rd_idx_q  <= '0;
      out_idx_q <= '0;
      rd_pend_q <= 1'b0;
      buf0_q    <= '0;
      buf1_q    <= '0;
      buf_cnt_q <= 2'd0;
      tmr_q     <= '0;
      te_en_q   <= 1'b0;
      ss_en_q   <= 1'b0;
      te_seen_q <= 1'b0;
      ss_seen_q <= 1'b0;
      te_flag_q <= 1'b0;
      ss_flag_q <= 1'b0;
      result_q  <= 2'b00;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_idx_q  <= rd_idx_d;
      out_idx_q <= out_idx_d;
      rd_pend_q <= Mem_Rd_En;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      buf_cnt_q <= buf_cnt_d;
      tmr_q     <= tmr_d;
      te_en_q   <= te_en_d;
      ss_en_q   <= ss_en_d;
      te_seen_q <= te_seen_d;
      ss_seen_q <= ss_seen_d;
      te_flag_q <= te_flag_d;
      ss_flag_q <= ss_flag_d;
      result_q  <= result_d;
      error_q   <= error_d;
    end
  end

endmodule

// File: tb/tb_compress_scheduler.sv
// Bench for compress_scheduler: queue-based reference model compared every cycle,
// directed jobs with hand-computed timing, and randomized jobs.
module tb_compress_scheduler;

  localparam int unsigned N  = 10;
  localparam int unsigned AW = 4;
  localparam int unsigned TO = 64;

  logic          SYS_CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          Start = 1'b0;
  logic [1:0]    Mode = 2'b00;
  logic          Busy;
  logic          Mem_Rd_En;
  logic [AW-1:0] Mem_Rd_Addr;
  logic [31:0]   Mem_Rd_Data = 32'd0;
  logic [31:0]   Counter;
  logic          Counter_Valid;
  logic          Counter_Ready = 1'b0;
  logic          Last;
  logic          Te_En;
  logic          Ss_En;
  logic          Te_Done = 1'b0;
  logic          Ss_Done = 1'b0;
  logic          Flag_TowerEncoding = 1'b0;
  logic          Flag_SketchSensing = 1'b0;
  logic          Done;
  logic [1:0]    Result;
  logic          Error;

  compress_scheduler #(
    .NUM_COUNTER(N),
    .ADDR_W     (AW),
    .TIMEOUT    (TO)
  ) u_dut (
    .SYS_CLK           (SYS_CLK),
    .RESET             (RESET),
    .Start             (Start),
    .Mode              (Mode),
    .Busy              (Busy),
    .Mem_Rd_En         (Mem_Rd_En),
    .Mem_Rd_Addr       (Mem_Rd_Addr),
    .Mem_Rd_Data       (Mem_Rd_Data),
    .Counter           (Counter),
    .Counter_Valid     (Counter_Valid),
    .Counter_Ready     (Counter_Ready),
    .Last              (Last),
    .Te_En             (Te_En),
    .Ss_En             (Ss_En),
    .Te_Done           (Te_Done),
    .Ss_Done           (Ss_Done),
    .Flag_TowerEncoding(Flag_TowerEncoding),
    .Flag_SketchSensing(Flag_SketchSensing),
    .Done              (Done),
    .Result            (Result),
    .Error             (Error)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int cyc = 0;
  always @(posedge SYS_CLK) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mem [16];
  bit mon_on = 1'b0;

  // Reference model: job phase plus explicit read/buffer bookkeeping.
  int          ph;
  int          issued, delivered, wait_cnt, pend_addr;
  bit          pend;
  logic [31:0] q [$];
  bit          m_te_en, m_ss_en, te_seen, ss_seen, te_f, ss_f, m_err;
  logic [1:0]  m_res;
  bit          job_done_seen;

  int          rec_t0, rec_first_valid, rec_last, rec_done, rec_rd_cnt, rec_max_addr;
  int          rec_delivered;
  bit          rec_ss_en, rec_err;
  logic [31:0] rec_last_data;
  logic [1:0]  rec_res;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    ph = 0; issued = 0; delivered = 0; wait_cnt = 0; pend_addr = 0; pend = 1'b0;
    q.delete();
    m_te_en = 1'b0; m_ss_en = 1'b0; te_seen = 1'b0; ss_seen = 1'b0;
    te_f = 1'b0; ss_f = 1'b0; m_err = 1'b0; m_res = 2'b00;
  endtask

  always @(negedge SYS_CLK) begin
    bit ev, acc, erd, complete;
    int occ;
    if (mon_on) begin
      ev  = (ph == 1) && (q.size() != 0);
      acc = ev && (Counter_Ready === 1'b1);
      occ = q.size() + int'(pend) - int'(acc);
      erd = (ph == 1) && (issued < int'(N)) && (occ <= 1);

      cmp("busy",   32'(Busy),          32'(ph != 0));
      cmp("done",   32'(Done),          32'(ph == 3));
      cmp("valid",  32'(Counter_Valid), 32'(ev));
      cmp("last",   32'(Last),          32'(ev && (delivered == int'(N) - 1)));
      cmp("rd_en",  32'(Mem_Rd_En),     32'(erd));
      cmp("te_en",  32'(Te_En),         32'(m_te_en));
      cmp("ss_en",  32'(Ss_En),         32'(m_ss_en));
      cmp("result", 32'(Result),        32'(m_res));
      cmp("error",  32'(Error),         32'(m_err));
      if (ev) cmp("counter", Counter, q[0]);
      if (erd) cmp("rd_addr", 32'(Mem_Rd_Addr), 32'(issued));

      if (ph == 0 && Start && !RESET) begin
        rec_t0 = cyc; rec_first_valid = -1; rec_last = -1; rec_done = -1;
        rec_rd_cnt = 0; rec_max_addr = -1; rec_delivered = 0; rec_ss_en = 1'b0;
      end
      if (Counter_Valid === 1'b1 && rec_first_valid < 0) rec_first_valid = cyc - rec_t0;
      if (Counter_Valid === 1'b1 && Counter_Ready) begin
        rec_delivered++;
        if (Last === 1'b1) begin
          rec_last = cyc - rec_t0;
          rec_last_data = Counter;
        end
      end
      if (Done === 1'b1) begin
        rec_done = cyc - rec_t0; rec_res = Result; rec_err = Error;
      end
      if (Mem_Rd_En === 1'b1) begin
        rec_rd_cnt++;
        if (int'(Mem_Rd_Addr) > rec_max_addr) rec_max_addr = int'(Mem_Rd_Addr);
      end
      if (Ss_En === 1'b1) rec_ss_en = 1'b1;
      if (!RESET && ph == 3) job_done_seen = 1'b1;

      if (RESET) begin
        model_reset();
      end else begin
        if (ph == 1 || ph == 2) begin
          if (m_te_en && Te_Done && !te_seen) begin te_seen = 1'b1; te_f = Flag_TowerEncoding; end
          if (m_ss_en && Ss_Done && !ss_seen) begin ss_seen = 1'b1; ss_f = Flag_SketchSensing; end
        end
        case (ph)
          0: if (Start) begin
            issued = 0; delivered = 0; pend = 1'b0; q.delete();
            te_seen = 1'b0; ss_seen = 1'b0; te_f = 1'b0; ss_f = 1'b0; m_res = 2'b00;
            if (Mode != 2'b00) begin
              ph = 1; m_te_en = Mode[0]; m_ss_en = Mode[1]; m_err = 1'b0;
            end else begin
              ph = 3; m_te_en = 1'b0; m_ss_en = 1'b0; m_err = 1'b1;
            end
          end
          1: begin
            if (acc) begin q.delete(0); delivered++; end
            if (pend) q.push_back(mem[pend_addr]);
            pend = erd; pend_addr = issued;
            if (erd) issued++;
            if (acc && delivered == int'(N)) begin ph = 2; wait_cnt = 0; end
          end
          2: begin
            complete = (!m_te_en || te_seen) && (!m_ss_en || ss_seen);
            if (complete) begin
              ph = 3; m_err = 1'b0; m_res = {ss_f, te_f};
            end else if (wait_cnt == int'(TO) - 1) begin
              ph = 3; m_err = 1'b1; m_res = {ss_f, te_f};
            end else begin
              wait_cnt++;
            end
          end
          default: begin ph = 0; m_te_en = 1'b0; m_ss_en = 1'b0; end
        endcase
      end
    end
  end

  // Memory: 1-cycle read latency, garbage when no read was issued.
  initial begin
    logic          en;
    logic [AW-1:0] a;
    forever begin
      @(negedge SYS_CLK);
      en = Mem_Rd_En;
      a  = Mem_Rd_Addr;
      @(posedge SYS_CLK);
      #1;
      Mem_Rd_Data = (en === 1'b1) ? mem[a] : $urandom;
    end
  end

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic set_idle();
    Start = 1'b0; Te_Done = 1'b0; Ss_Done = 1'b0;
    Mode = 2'($urandom); Counter_Ready = 1'($urandom);
  endtask

  task automatic idle_cycles(input int n, input bit stray_done);
    for (int i = 0; i < n; i++) begin
      set_idle();
      Te_Done = stray_done; Ss_Done = stray_done;
      Flag_TowerEncoding = 1'($urandom); Flag_SketchSensing = 1'($urandom);
      tick();
    end
    set_idle();
  endtask

  // rdy: 0 = always ready, 1 = 1,0,0 pattern, 2 = random (75% ready).
  task automatic run_job(input logic [1:0] md, input int te_at, input int ss_at,
                         input bit te_flag, input bit ss_flag, input int rdy, input bit stray);
    bit finished;
    finished = 1'b0;
    job_done_seen = 1'b0;
    for (int t = 0; t < 400; t++) begin
      Start = (t == 0) || (stray && (t == 5 || t == 15 || t == 22));
      Mode  = (t == 0) ? md : 2'($urandom);
      case (rdy)
        0:       Counter_Ready = 1'b1;
        1:       Counter_Ready = (t % 3 == 0);
        default: Counter_Ready = ($urandom_range(0, 3) != 0);
      endcase
      Te_Done = (t == te_at);
      Ss_Done = (t == ss_at);
      Flag_TowerEncoding = (t == te_at) ? te_flag : 1'($urandom);
      Flag_SketchSensing = (t == ss_at) ? ss_flag : 1'($urandom);
      tick();
      if (job_done_seen) begin
        finished = 1'b1;
        break;
      end
    end
    set_idle();
    if (!finished) begin
      miscompares++;
      $display("FAIL job_timeout: no Done within 400 cycles, expected one");
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    model_reset();
    RESET = 1'b1;
    tick();
    tick();
    mon_on = 1'b1;
    RESET = 1'b0;
    set_idle();
    @(negedge SYS_CLK);
    cmp("rst_busy",   32'(Busy),          32'd0);
    cmp("rst_valid",  32'(Counter_Valid), 32'd0);
    cmp("rst_rd_en",  32'(Mem_Rd_En),     32'd0);
    cmp("rst_addr",   32'(Mem_Rd_Addr),   32'd0);
    cmp("rst_result", 32'(Result),        32'd0);
    cmp("rst_error",  32'(Error),         32'd0);
    tick();
    idle_cycles(2, 1'b0);

    // Both engines, full throughput.
    run_job(2'b11, 15, 18, 1'b1, 1'b0, 0, 1'b0);
    cmp("t1_first_valid", 32'(rec_first_valid), 32'd3);
    cmp("t1_last_cycle",  32'(rec_last),        32'd12);
    cmp("t1_last_data",   rec_last_data,        mem[9]);
    cmp("t1_done_cycle",  32'(rec_done),        32'd19);
    cmp("t1_result",      32'(rec_res),         32'b01);
    cmp("t1_error",       32'(rec_err),         32'd0);

    // TowerEncoding only, stalling consumer.
    run_job(2'b01, 45, -1, 1'b1, 1'b0, 1, 1'b0);
    cmp("t2_delivered", 32'(rec_delivered), 32'd10);
    cmp("t2_rd_count",  32'(rec_rd_cnt),    32'd10);
    cmp("t2_max_addr",  32'(rec_max_addr),  32'd9);
    cmp("t2_ss_en",     32'(rec_ss_en),     32'd0);
    cmp("t2_result",    32'(rec_res),       32'b01);

    // SketchSensing never finishes: timeout 64 cycles after WAIT entry at cycle 13.
    run_job(2'b10, -1, -1, 1'b0, 1'b0, 0, 1'b0);
    cmp("t3_done_cycle", 32'(rec_done), 32'd77);
    cmp("t3_error",      32'(rec_err),  32'd1);
    cmp("t3_result",     32'(rec_res),  32'b00);

    // Illegal mode.
    run_job(2'b00, -1, -1, 1'b0, 1'b0, 0, 1'b0);
    cmp("t4_done_cycle", 32'(rec_done),   32'd1);
    cmp("t4_error",      32'(rec_err),    32'd1);
    cmp("t4_rd_count",   32'(rec_rd_cnt), 32'd0);
    idle_cycles(1, 1'b0);

    // Reset in cycle 6 of a job, fresh Start in cycle 9.
    for (int t = 0; t < 9; t++) begin
      Start = (t == 0); Mode = 2'b01; Counter_Ready = 1'b1;
      RESET = (t == 6);
      tick();
      if (t == 6) begin
        RESET = 1'b0;
        Start = 1'b0;
        @(negedge SYS_CLK);
        cmp("abort_busy",  32'(Busy),          32'd0);
        cmp("abort_rd_en", 32'(Mem_Rd_En),     32'd0);
        cmp("abort_valid", 32'(Counter_Valid), 32'd0);
        cmp("abort_te_en", 32'(Te_En),         32'd0);
        @(posedge SYS_CLK);
        #1;
        t++;
      end
    end
    run_job(2'b01, 20, -1, 1'b1, 1'b0, 0, 1'b0);
    cmp("t5_delivered", 32'(rec_delivered), 32'd10);
    cmp("t5_done_cycle", 32'(rec_done),     32'd21);

    // Stray Starts mid-job and stray done strobes while idle.
    idle_cycles(3, 1'b1);
    run_job(2'b11, 20, 25, 1'b0, 1'b1, 0, 1'b1);
    cmp("t6_done_cycle", 32'(rec_done), 32'd26);
    cmp("t6_result",     32'(rec_res),  32'b10);
    cmp("t6_error",      32'(rec_err),  32'd0);

    // Randomized jobs against the model.
    for (int j = 0; j < 40; j++) begin
      int te_at, ss_at;
      te_at = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 70));
      ss_at = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 70));
      run_job(2'($urandom_range(0, 3)), te_at, ss_at, 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 2)), 1'($urandom));
      idle_cycles(int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/compress_scheduler.md
Name: compress_scheduler

Overview:
Sequencer that runs one compression job over a sketch row. On a Start request it reads NUM_COUNTER 32-bit counters from sketch memory (1-cycle read latency) and streams them, with valid/ready flow control, into the TowerEncoding and/or SketchSensing engines chosen by Mode. It then waits for the selected engines to finish and reports their result flags, or an error on timeout or illegal mode. It sits between the host/control logic and the compression engines.

Parameters:
NUM_COUNTER, 10, counters per job (≥1)
ADDR_W, 4, memory address width; 2^ADDR_W ≥ NUM_COUNTER
TIMEOUT, 64, max cycles in WAIT before error (≥1)

Ports:
SYS_CLK  in  1  clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
Start  in  1  job request; sampled only in IDLE
Mode  in  2  bit0 = TowerEncoding, bit1 = SketchSensing; sampled with Start
Busy  out  1  high from Start acceptance through the Done cycle
Mem_Rd_En  out  1  memory read strobe
Mem_Rd_Addr  out  ADDR_W  read address
Mem_Rd_Data  in  32  valid the cycle after Mem_Rd_En
Counter  out  32  counter to engines
Counter_Valid  out  1  Counter valid
Counter_Ready  in  1  engines accept; a transfer occurs when Valid & Ready
Last  out  1  qualifies the final counter of the job
Te_En  out  1  TowerEncoding enable for this job
Ss_En  out  1  SketchSensing enable for this job
Te_Done  in  1  TowerEncoding finished (pulse or level)
Ss_Done  in  1  SketchSensing finished
Flag_TowerEncoding  in  1  TE result; sampled when Te_Done is seen
Flag_SketchSensing  in  1  SS result; sampled when Ss_Done is seen
Done  out  1  one-cycle job-complete pulse
Result  out  2  {ss_flag, te_flag}; held from Done until next accepted Start
Error  out  1  valid with Done; held like Result

Behaviour:
- Reset: all outputs 0, Mem_Rd_Addr 0, state IDLE, counters, buffer and latches cleared. Reset mid-job abandons the job: no Done, no further reads.
- States: IDLE, STREAM, WAIT, REPORT.
- IDLE:
  - Start=1, Mode≠00 → STREAM. Latch Mode. Te_En=Mode[0], Ss_En=Mode[1]. Clear Result/Error.
  - Start=1, Mode=00 → REPORT with Error=1, Result=00, no reads issued.
  - Start while not IDLE is ignored.
- STREAM, reads:
  - Addresses 0..NUM_COUNTER-1 issued in order, at most one per cycle.
  - Read data goes into a 2-entry output skid buffer.
  - A read issues only if buffered entries + in-flight reads after this cycle's accept is ≤1. The buffer therefore never overflows.
  - Throughput is 1 counter/cycle with Ready held high.
- STREAM, timing with Ready=1: Start high in cycle 0 → Mem_Rd_En addr0 in cycle 1 → data in cycle 2 → Counter_Valid with counter0 in cycle 3. Counter k appears in cycle 3+k.
- STREAM, output rules:
  - Counter/Valid/Last hold stable while Valid & !Ready.
  - Last=1 only with counter NUM_COUNTER-1.
  - The Last transfer → WAIT.
- Done latching:
  - Te_Done and Ss_Done are captured into sticky bits from STREAM entry onward. Done flags in IDLE are ignored.
  - Flag_* is captured in the same cycle as the corresponding done.
  - Done for a disabled engine is ignored.
- WAIT:
  - A timeout counter starts at 0 on entry and increments each cycle.
  - When all enabled sticky done bits are set (including a done arriving this cycle) → REPORT, Error=0.
  - If the count reaches TIMEOUT first → REPORT, Error=1. Flags already captured are kept; missing flags read 0.
  - Simultaneous completion and timeout in the same cycle: completion wins.
- REPORT: Done=1 for exactly one cycle. Result and Error are valid. Busy, Te_En and Ss_En are still high this cycle. → IDLE next cycle.
- Busy, Te_En and Ss_En go low in the cycle after Done.
- Start in the cycle after Done is accepted normally.

Test Plan:
- Mode=11, Ready=1, flags TE=1/SS=0, Te_Done at cycle 15, Ss_Done at cycle 18 → Counter_Valid cycles 3–12, Last at cycle 12 with mem[9], Done at cycle 19, Result=2'b01, Error=0.
- Mode=01, Ready toggling 1,0,0,1,… → all 10 counters delivered once, in order, values stable while stalled, no read beyond addr 9, Ss_En=0 throughout.
- Mode=10, Ss_Done never asserted, TIMEOUT=64 → Done exactly 64 cycles after WAIT entry, Error=1, Result=00.
- Mode=00 with Start → Done at cycle 1, Error=1, zero Mem_Rd_En pulses.
- RESET asserted at cycle 6 of a job → next cycle all outputs 0, no Done. A new Start at cycle 9 runs a complete job from addr 0.
- Start pulses during STREAM/WAIT, and Te_Done during IDLE → ignored; the single job completes with the correct Result.
